// File: rtl/mult_accumulate_stage_if.sv
// Product-stream input and dot-product result handshake of mult_accumulate_stage.
// slave is the accumulator's view; master is the producer/consumer side.
interface mult_accumulate_stage_if #(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
) ();
  localparam int ACC_W = 2*WIDTH + GUARD;

  logic               in_valid;
  logic [2*WIDTH-1:0] in_prod;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               out_ovf;

  modport slave (
    input  in_valid, in_prod, out_ready,
    output out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_prod, out_ready,
    input  out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/mult_accumulate_stage.sv
// Sums groups of LEN unsigned products into a registered dot-product result.
// The input is never stalled; a result lost to a full output register raises overrun.
module mult_accumulate_stage #(
  parameter int WIDTH = 8,
  parameter int LEN   = 4,
  parameter int GUARD = 4
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           clear,
  mult_accumulate_stage_if.slave         bus,
  output logic                           overrun,
  output logic [7:0]                     count
);
  localparam int ACC_W = 2*WIDTH + GUARD;
  localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  // Handshake: a result transfers on any edge with out_valid=1 and out_ready=1.
  // There is no in_ready; every in_valid cycle is consumed unless clear=1.

  // The FSM state is the counter itself: COLLECT while cnt < LEN-1, LAST at LEN-1.
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic             acc_ovf, acc_ovf_n;
  logic             out_valid_q, out_valid_n;
  logic [ACC_W-1:0] out_sum_q, out_sum_n;
  logic             out_ovf_q, out_ovf_n;
  logic             overrun_q, overrun_n;

  logic [ACC_W:0]   sum_ext;
  logic             take;
  logic             is_last;
  logic             complete;

  assign sum_ext  = {1'b0, acc} + {{(GUARD+1){1'b0}}, bus.in_prod};
  assign take     = bus.in_valid && !clear;
  assign is_last  = (cnt == LAST_CNT);
  assign complete = take && is_last;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt         <= '0;
      acc         <= '0;
      acc_ovf     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      acc         <= acc_n;
      acc_ovf     <= acc_ovf_n;
      out_valid_q <= out_valid_n;
      out_sum_q   <= out_sum_n;
      out_ovf_q   <= out_ovf_n;
      overrun_q   <= overrun_n;
    end
  end

  // Completion empties the accumulator so the next group can start immediately.
  always_comb begin
    cnt_n     = cnt;
    acc_n     = acc;
    acc_ovf_n = acc_ovf;
    if (clear || complete) begin
      cnt_n     = '0;
      acc_n     = '0;
      acc_ovf_n = 1'b0;
    end else if (take) begin
      cnt_n     = cnt + CNT_W'(1);
      acc_n     = sum_ext[ACC_W-1:0];
      acc_ovf_n = acc_ovf | sum_ext[ACC_W];
    end
  end

  // Output register: clear leaves a pending result readable but resets overrun.
  always_comb begin
    out_valid_n = out_valid_q && !bus.out_ready;
    out_sum_n   = out_sum_q;
    out_ovf_n   = out_ovf_q;
    overrun_n   = overrun_q;
    if (complete) begin
      out_valid_n = 1'b1;
      out_sum_n   = sum_ext[ACC_W-1:0];
      out_ovf_n   = acc_ovf | sum_ext[ACC_W];
      if (out_valid_q && !bus.out_ready) overrun_n = 1'b1;
    end
    if (clear) overrun_n = 1'b0;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign overrun       = overrun_q;
  assign count         = 8'(cnt);
endmodule
